// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream FIFO reader slice.
//   - data_bits(): stream data width in bits, derived from the byte count
//   - buf_state_e: occupancy encoding of the two-entry output buffer
//   - BEAT_CNT_W:  width of the packet beat counter used for tlast framing
package axis_pkg;

  localparam int unsigned BEAT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  function automatic int unsigned data_bits(input int unsigned n_bytes);
    return 8 * n_bytes;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output buffer (main + skid) for the FIFO reader.
// Absorbs the FIFO read latency so a word already in flight always has a
// slot, even if the consumer stalls in the same cycle.
//
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   in_valid       capture strobe (FIFO read data valid this cycle)
//   in_data        payload to capture ({keep, data})
//   out_ready      downstream ready
//   out_valid      main entry valid (registered)
//   out_data       main entry payload (registered)
//   held           number of buffered entries (0..2)
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | nothing buffered
// ST_ONE   | main valid, skid free
// ST_TWO   | main and skid valid; skid drains into main on fire
module axis_skid_buffer
  import axis_pkg::*;
#(
  parameter int unsigned W = 36
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   held
);

  buf_state_e   state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         main_v_q;
  logic         fire;

  assign fire      = main_v_q & out_ready;
  assign out_valid = main_v_q;
  assign out_data  = main_q;
  assign held      = {state_q == ST_TWO, state_q == ST_ONE};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            main_q   <= in_data;
            main_v_q <= 1'b1;
            state_q  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_valid && fire) begin
            main_q <= in_data;
          end else if (in_valid) begin
            skid_q  <= in_data;
            state_q <= ST_TWO;
          end else if (fire) begin
            main_v_q <= 1'b0;
            state_q  <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Capture without fire cannot happen here: the read-issue rule in
          // the parent never lets a third word be in flight.
          if (fire) begin
            main_q <= skid_q;
            if (in_valid) begin
              skid_q <= in_data;
            end else begin
              state_q <= ST_ONE;
            end
          end
        end
        default: begin
          state_q  <= ST_EMPTY;
          main_v_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/axis_fifo_reader.sv
// AXI4-Stream master draining a synchronous FIFO (one-cycle read latency).
// Issues pops only when the two-entry output buffer is guaranteed to have a
// slot for the word when it arrives, and sustains one beat per cycle while
// the consumer is ready.
//
// Optional feature macro: AXIS_TLAST_EN
//   defined   - 16-bit beat counter frames packets of PKT_LEN beats on tlast
//   undefined - m_axis_tlast tied low, no counter
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   empty           FIFO empty flag
//   rd_data/rd_keep FIFO read data and byte strobes, valid a cycle after r_en
//   r_en            FIFO pop request (combinational)
//   m_axis_*        outbound stream (tdata, tkeep, tvalid, tlast, tready)
module axis_fifo_reader
  import axis_pkg::*;
#(
  parameter  int unsigned t_data_w  = 4,
  parameter  int unsigned PKT_LEN   = 16,
  localparam int unsigned DATA_BITS = data_bits(t_data_w)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 empty,
  input  logic [DATA_BITS-1:0] rd_data,
  input  logic [t_data_w-1:0]  rd_keep,
  output logic                 r_en,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic [t_data_w-1:0]  m_axis_tkeep,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready
);

  if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_pkt_len_bad
    $error("axis_fifo_reader: PKT_LEN must be in 1..65535");
  end

  localparam int unsigned PAY_W = DATA_BITS + t_data_w;

  logic             fire;
  logic             inflight;
  logic [1:0]       held;
  logic [2:0]       occ;
  logic [2:0]       limit;
  logic [PAY_W-1:0] buf_out;

  assign fire = m_axis_tvalid & m_axis_tready;

  // held + inflight - fire < 2, rearranged to avoid unsigned underflow.
  assign occ   = {1'b0, held} + {2'b00, inflight};
  assign limit = 3'd2 + {2'b00, fire};
  assign r_en  = aresetn & ~empty & (occ < limit);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inflight <= 1'b0;
    end else begin
      inflight <= r_en;
    end
  end

  axis_skid_buffer #(
    .W (PAY_W)
  ) u_buf (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (inflight),
    .in_data   ({rd_keep, rd_data}),
    .out_ready (m_axis_tready),
    .out_valid (m_axis_tvalid),
    .out_data  (buf_out),
    .held      (held)
  );

  assign m_axis_tdata = buf_out[DATA_BITS-1:0];
  assign m_axis_tkeep = buf_out[PAY_W-1:DATA_BITS];

`ifdef AXIS_TLAST_EN
  localparam logic [BEAT_CNT_W-1:0] LAST_IDX = BEAT_CNT_W'(PKT_LEN - 1);

  logic [BEAT_CNT_W-1:0] beat_cnt_q;
  logic [BEAT_CNT_W-1:0] beat_cnt_nxt;
  logic                  main_valid_nxt;
  logic                  tlast_q;

  // The main entry always holds the next beat to fire, so its index is the
  // number of fires so far modulo PKT_LEN.
  always_comb begin
    beat_cnt_nxt = beat_cnt_q;
    if (fire) begin
      beat_cnt_nxt = (beat_cnt_q == LAST_IDX) ? '0 : beat_cnt_q + BEAT_CNT_W'(1);
    end
  end

  assign main_valid_nxt = inflight | held[1] | (m_axis_tvalid & ~m_axis_tready);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt_q <= '0;
      tlast_q    <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_nxt;
      tlast_q    <= main_valid_nxt & (beat_cnt_nxt == LAST_IDX);
    end
  end

  assign m_axis_tlast = tlast_q;
`else
  assign m_axis_tlast = 1'b0;
`endif

endmodule
